// File: rtl/dm_bus_ctrl_pkg.sv
// Shared definitions for the data-side bus sequencer: address windows,
// slave indices, FSM encoding and a window-compare helper. The M-stage
// load-extend and exception logic use the same constants.
package dm_bus_ctrl_pkg;

    localparam logic [31:0] DM_BEGIN  = 32'h0000_0000;
    localparam logic [31:0] DM_END    = 32'h0000_2FFF;
    localparam logic [31:0] TC1_BEGIN = 32'h0000_7F00;
    localparam logic [31:0] TC1_END   = 32'h0000_7F0B;
    localparam logic [31:0] TC2_BEGIN = 32'h0000_7F10;
    localparam logic [31:0] TC2_END   = 32'h0000_7F1B;

    // Maximum BUSY cycles spent waiting on s_ready (legal range 2..255)
    localparam int TIMEOUT_DEFAULT = 8;

    localparam int NUM_SLV = 3;
    localparam int SLV_DM  = 0;
    localparam int SLV_TC1 = 1;
    localparam int SLV_TC2 = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Inclusive at both bounds
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/dm_bus_ctrl_if.sv
// M-stage request/response port and the shared slave bus, bundled together.
// The slave modport is the controller's view; master is the environment's.
interface dm_bus_ctrl_if;
    import dm_bus_ctrl_pkg::*;

    logic                req_valid;
    logic                req_we;
    logic [31:0]         req_addr;
    logic [31:0]         req_wdata;
    logic [3:0]          req_byteen;
    logic                req_ready;

    logic                rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;

    logic                s_valid;
    logic [NUM_SLV-1:0]  s_sel;
    logic                s_we;
    logic [31:0]         s_addr;
    logic [31:0]         s_wdata;
    logic [3:0]          s_byteen;
    logic [NUM_SLV-1:0]  s_ready;
    logic [31:0]         s_rdata_dm;
    logic [31:0]         s_rdata_tc1;
    logic [31:0]         s_rdata_tc2;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_byteen,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output s_valid, s_sel, s_we, s_addr, s_wdata, s_byteen,
        input  s_ready, s_rdata_dm, s_rdata_tc1, s_rdata_tc2
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_byteen,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  s_valid, s_sel, s_we, s_addr, s_wdata, s_byteen,
        output s_ready, s_rdata_dm, s_rdata_tc1, s_rdata_tc2
    );

endinterface

// File: rtl/dm_addr_decode.sv
// Combinational address decode: one-hot slave select plus a fault flag for
// unmapped addresses and non-word timer accesses. Shared with the M-stage
// exception check, so a faulting access always reports sel = 0.
module dm_addr_decode
    import dm_bus_ctrl_pkg::*;
(
    input  logic [31:0]        addr,
    input  logic [3:0]         byteen,
    output logic [NUM_SLV-1:0] sel,
    output logic               fault
);

    logic [NUM_SLV-1:0] win;

    // Window match, then qualify with the timer word-access rule
    always_comb begin
        win          = '0;
        win[SLV_DM]  = in_window(addr, DM_BEGIN, DM_END);
        win[SLV_TC1] = in_window(addr, TC1_BEGIN, TC1_END);
        win[SLV_TC2] = in_window(addr, TC2_BEGIN, TC2_END);
        fault        = (win == '0) ||
                       ((win[SLV_TC1] || win[SLV_TC2]) && (byteen != 4'hF));
        sel          = fault ? '0 : win;
    end

endmodule

// File: rtl/dm_bus_ctrl.sv
// Data-bus access sequencer: accepts one M-stage load/store at a time,
// hands it to the decoded slave with a valid/ready handshake, and returns
// a single-cycle response. Faults and timeouts never touch a slave.
module dm_bus_ctrl
    import dm_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         exc_flush,
    output logic         stall,
    dm_bus_ctrl_if.slave bus
);

    state_t             state_q, state_d;
    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_fault;
    logic               we_q;
    logic [31:0]        addr_q, wdata_q, rdata_q;
    logic [3:0]         byteen_q;
    logic [NUM_SLV-1:0] sel_q;
    logic [7:0]         cnt_q;
    logic               drop_q, err_q;
    logic               accept, hit, expired;
    logic               req_ready, s_valid, rsp_valid;
    logic [31:0]        sel_rdata;

    dm_addr_decode u_decode (
        .addr   (bus.req_addr),
        .byteen (bus.req_byteen),
        .sel    (dec_sel),
        .fault  (dec_fault)
    );

    assign sel_rdata = ({32{sel_q[SLV_DM]}}  & bus.s_rdata_dm)  |
                       ({32{sel_q[SLV_TC1]}} & bus.s_rdata_tc1) |
                       ({32{sel_q[SLV_TC2]}} & bus.s_rdata_tc2);

    // State register; reset returns to IDLE at once, dropping s_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs; a flush in RESP also hides the pulse
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        hit       = 1'b0;
        expired   = 1'b0;
        req_ready = 1'b0;
        s_valid   = 1'b0;
        rsp_valid = 1'b0;
        stall     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                accept    = bus.req_valid && !exc_flush;
                stall     = accept;
                if (accept) state_d = dec_fault ? ST_RESP : ST_BUSY;
            end
            ST_BUSY: begin
                s_valid = 1'b1;
                stall   = 1'b1;
                hit     = |(bus.s_ready & sel_q);
                expired = (cnt_q == 8'(TIMEOUT - 1));
                if (hit || expired) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = !drop_q && !exc_flush;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches, timeout counter, drop flag and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q     <= bus.req_we;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        byteen_q <= bus.req_byteen;
                        sel_q    <= dec_sel;
                        cnt_q    <= '0;
                        drop_q   <= 1'b0;
                        err_q    <= dec_fault;
                        rdata_q  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (exc_flush) drop_q <= 1'b1;
                    if (hit) begin
                        rdata_q <= we_q ? 32'd0 : sel_rdata;
                        err_q   <= 1'b0;
                    end else if (expired) begin
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    sel_q  <= '0;
                    drop_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.s_valid   = s_valid;
    assign bus.s_sel     = sel_q;
    assign bus.s_we      = we_q;
    assign bus.s_addr    = addr_q;
    assign bus.s_wdata   = wdata_q;
    assign bus.s_byteen  = byteen_q;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign bus.rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Directed bench for dm_bus_ctrl: loads, stores, faults, timeout, flush
// and mid-access reset, with hand-computed expectations.
module tb_dm_bus_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic exc_flush;
    logic stall;

    int vectors     = 0;
    int miscompares = 0;

    dm_bus_ctrl_if bus ();

    dm_bus_ctrl #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .exc_flush (exc_flush),
        .stall     (stall),
        .bus       (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_addr    = 32'd0;
        bus.req_wdata   = 32'd0;
        bus.req_byteen  = 4'd0;
        bus.s_ready     = 3'b000;
        bus.s_rdata_dm  = 32'd0;
        bus.s_rdata_tc1 = 32'd0;
        bus.s_rdata_tc2 = 32'd0;
        exc_flush       = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_byteen = be;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2;
        chk_b("rst_req_ready", bus.req_ready, 1'b1);
        chk_b("rst_s_valid",   bus.s_valid,   1'b0);
        chk_b("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk_b("rst_stall",     stall,         1'b0);
        chk_w("rst_s_sel",     {29'd0, bus.s_sel}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        settle();

        // DM load, ready on first BUSY cycle
        tick(); drive_req(1'b0, 32'h10, 32'd0, 4'hF); settle();
        chk_b("dmld_c0_ready", bus.req_ready, 1'b1);
        chk_b("dmld_c0_stall", stall, 1'b1);
        chk_b("dmld_c0_svalid", bus.s_valid, 1'b0);
        tick(); bus.s_ready = 3'b001; bus.s_rdata_dm = 32'hDEADBEEF; settle();
        chk_b("dmld_c1_svalid", bus.s_valid, 1'b1);
        chk_w("dmld_c1_ssel", {29'd0, bus.s_sel}, 32'd1);
        chk_w("dmld_c1_saddr", bus.s_addr, 32'h10);
        chk_b("dmld_c1_stall", stall, 1'b1);
        chk_b("dmld_c1_rspv", bus.rsp_valid, 1'b0);
        tick(); clear_inputs(); settle();
        chk_b("dmld_c2_rspv", bus.rsp_valid, 1'b1);
        chk_w("dmld_c2_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk_b("dmld_c2_err", bus.rsp_err, 1'b0);
        chk_b("dmld_c2_stall", stall, 1'b0);
        chk_b("dmld_c2_ready", bus.req_ready, 1'b0);
        tick(); settle();
        chk_b("dmld_c3_rspv", bus.rsp_valid, 1'b0);
        chk_b("dmld_c3_ready", bus.req_ready, 1'b1);

        // TC1 word store, ready in third BUSY cycle; request changes ignored
        tick(); drive_req(1'b1, 32'h7F04, 32'h5, 4'hF); settle();
        tick(); settle();
        chk_w("tc1st_ssel", {29'd0, bus.s_sel}, 32'd2);
        chk_b("tc1st_swe", bus.s_we, 1'b1);
        chk_w("tc1st_swdata", bus.s_wdata, 32'h5);
        chk_w("tc1st_saddr", bus.s_addr, 32'h7F04);
        tick(); bus.req_addr = 32'h7F08; bus.req_wdata = 32'h9; bus.s_ready = 3'b101; settle();
        chk_b("tc1st_c2_svalid", bus.s_valid, 1'b1);
        chk_w("tc1st_c2_saddr", bus.s_addr, 32'h7F04);
        chk_w("tc1st_c2_swdata", bus.s_wdata, 32'h5);
        chk_b("tc1st_c2_rspv", bus.rsp_valid, 1'b0);
        tick(); bus.s_ready = 3'b010; bus.s_rdata_tc1 = 32'h1234; settle();
        chk_b("tc1st_c3_svalid", bus.s_valid, 1'b1);
        tick(); clear_inputs(); settle();
        chk_b("tc1st_rspv", bus.rsp_valid, 1'b1);
        chk_b("tc1st_err", bus.rsp_err, 1'b0);
        chk_w("tc1st_rdata", bus.rsp_rdata, 32'd0);
        tick(); settle();

        // Halfword access to TC2 faults without a slave access
        tick(); drive_req(1'b0, 32'h7F14, 32'd0, 4'b0011); settle();
        chk_b("tc2hw_stall", stall, 1'b1);
        chk_b("tc2hw_c0_svalid", bus.s_valid, 1'b0);
        tick(); clear_inputs(); settle();
        chk_b("tc2hw_rspv", bus.rsp_valid, 1'b1);
        chk_b("tc2hw_err", bus.rsp_err, 1'b1);
        chk_b("tc2hw_svalid", bus.s_valid, 1'b0);
        chk_w("tc2hw_rdata", bus.rsp_rdata, 32'd0);
        chk_w("tc2hw_ssel", {29'd0, bus.s_sel}, 32'd0);
        tick(); settle();
        chk_b("tc2hw_after_rspv", bus.rsp_valid, 1'b0);

        // Unmapped address just past DM
        tick(); drive_req(1'b0, 32'h3000, 32'd0, 4'hF); settle();
        chk_b("unmap_c0_svalid", bus.s_valid, 1'b0);
        tick(); clear_inputs(); settle();
        chk_b("unmap_rspv", bus.rsp_valid, 1'b1);
        chk_b("unmap_err", bus.rsp_err, 1'b1);
        chk_b("unmap_svalid", bus.s_valid, 1'b0);
        tick(); settle();

        // Last DM byte, byte access is legal for DM
        tick(); drive_req(1'b0, 32'h2FFF, 32'd0, 4'b1000); settle();
        tick(); bus.s_ready = 3'b001; bus.s_rdata_dm = 32'hAB00_0000; settle();
        chk_w("dmend_ssel", {29'd0, bus.s_sel}, 32'd1);
        chk_w("dmend_sbyteen", {28'd0, bus.s_byteen}, 32'h8);
        tick(); clear_inputs(); settle();
        chk_b("dmend_rspv", bus.rsp_valid, 1'b1);
        chk_b("dmend_err", bus.rsp_err, 1'b0);
        chk_w("dmend_rdata", bus.rsp_rdata, 32'hAB00_0000);
        tick(); settle();

        // Last TC2 address, word access
        tick(); drive_req(1'b0, 32'h7F1B, 32'd0, 4'hF); settle();
        tick(); bus.s_ready = 3'b100; bus.s_rdata_tc2 = 32'h77; settle();
        chk_w("tc2end_ssel", {29'd0, bus.s_sel}, 32'd4);
        tick(); clear_inputs(); settle();
        chk_b("tc2end_rspv", bus.rsp_valid, 1'b1);
        chk_w("tc2end_rdata", bus.rsp_rdata, 32'h77);
        tick(); settle();

        // One past TC1 end is unmapped
        tick(); drive_req(1'b0, 32'h7F0C, 32'd0, 4'hF); settle();
        tick(); clear_inputs(); settle();
        chk_b("tc1gap_rspv", bus.rsp_valid, 1'b1);
        chk_b("tc1gap_err", bus.rsp_err, 1'b1);
        chk_b("tc1gap_svalid", bus.s_valid, 1'b0);
        tick(); settle();

        // Timeout: DM never ready, exactly 8 BUSY cycles
        tick(); drive_req(1'b0, 32'h100, 32'd0, 4'hF); settle();
        for (int i = 1; i <= 8; i++) begin
            tick(); settle();
            chk_b($sformatf("to_busy%0d_svalid", i), bus.s_valid, 1'b1);
            chk_b($sformatf("to_busy%0d_rspv", i), bus.rsp_valid, 1'b0);
        end
        tick(); clear_inputs(); settle();
        chk_b("to_rspv", bus.rsp_valid, 1'b1);
        chk_b("to_err", bus.rsp_err, 1'b1);
        chk_b("to_svalid", bus.s_valid, 1'b0);
        tick(); settle();

        // Ready on the 8th BUSY cycle wins over timeout
        tick(); drive_req(1'b0, 32'h104, 32'd0, 4'hF); settle();
        for (int i = 1; i <= 7; i++) begin
            tick(); settle();
        end
        tick(); bus.s_ready = 3'b001; bus.s_rdata_dm = 32'hCAFEF00D; settle();
        chk_b("to8_svalid", bus.s_valid, 1'b1);
        tick(); clear_inputs(); settle();
        chk_b("to8_rspv", bus.rsp_valid, 1'b1);
        chk_b("to8_err", bus.rsp_err, 1'b0);
        chk_w("to8_rdata", bus.rsp_rdata, 32'hCAFEF00D);
        tick(); settle();

        // Flush while a store is BUSY: store completes, response dropped
        tick(); drive_req(1'b1, 32'h200, 32'hA5A5, 4'hF); settle();
        tick(); exc_flush = 1'b1; settle();
        chk_b("fl_c1_svalid", bus.s_valid, 1'b1);
        chk_b("fl_c1_stall", stall, 1'b1);
        tick(); exc_flush = 1'b0; bus.s_ready = 3'b001; settle();
        chk_b("fl_c2_svalid", bus.s_valid, 1'b1);
        chk_b("fl_c2_swe", bus.s_we, 1'b1);
        tick(); clear_inputs(); settle();
        chk_b("fl_resp_rspv", bus.rsp_valid, 1'b0);
        chk_b("fl_resp_stall", stall, 1'b0);
        chk_b("fl_resp_ready", bus.req_ready, 1'b0);
        tick(); settle();
        chk_b("fl_idle_ready", bus.req_ready, 1'b1);

        // Flush in IDLE blocks acceptance
        tick(); drive_req(1'b0, 32'h10, 32'd0, 4'hF); exc_flush = 1'b1; settle();
        chk_b("flidle_stall", stall, 1'b0);
        tick(); clear_inputs(); settle();
        chk_b("flidle_svalid", bus.s_valid, 1'b0);
        chk_b("flidle_rspv", bus.rsp_valid, 1'b0);

        // Reset mid-BUSY, then a normal TC2 access
        tick(); drive_req(1'b0, 32'h20, 32'd0, 4'hF); settle();
        tick(); settle();
        chk_b("rstmid_pre_svalid", bus.s_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk_b("rstmid_svalid", bus.s_valid, 1'b0);
        chk_b("rstmid_ready", bus.req_ready, 1'b1);
        clear_inputs();
        tick();
        reset = 1'b0;
        settle();
        tick(); drive_req(1'b0, 32'h7F10, 32'd0, 4'hF); settle();
        chk_b("post_rst_ready", bus.req_ready, 1'b1);
        tick(); bus.s_ready = 3'b100; bus.s_rdata_tc2 = 32'h0BADF00D; settle();
        chk_w("post_rst_ssel", {29'd0, bus.s_sel}, 32'd4);
        tick(); clear_inputs(); settle();
        chk_b("post_rst_rspv", bus.rsp_valid, 1'b1);
        chk_w("post_rst_rdata", bus.rsp_rdata, 32'h0BADF00D);
        chk_b("post_rst_err", bus.rsp_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_bus_ctrl.md
# dm_bus_ctrl

Data-bus access sequencer between the CPU M-stage memory port and the three data-side slaves: data memory, timer 1 and timer 2. It accepts one load/store request at a time, decodes and range-checks the address, and drives a valid/ready handshake to the selected slave. It then returns read data or an error flag to the M stage, and raises `stall` to freeze the pipeline while the access is outstanding. Unmapped addresses, non-word timer accesses and slave timeouts complete with `rsp_err` and never reach a slave.

## Interface
- `DM_BEGIN`, 32'h0000_0000, first data-memory byte address
- `DM_END`, 32'h0000_2FFF, last data-memory byte address
- `TC1_BEGIN` / `TC1_END`, 32'h0000_7F00 / 32'h0000_7F0B, timer 1 window
- `TC2_BEGIN` / `TC2_END`, 32'h0000_7F10 / 32'h0000_7F1B, timer 2 window
- `TIMEOUT`, 8, maximum BUSY cycles waiting for `s_ready`; valid range 2..255
- `clk`, in, 1, system clock
- `reset`, in, 1, asynchronous, active-high reset
- `req_valid`, in, 1, M stage presents an access
- `req_we`, in, 1, 1 = store, 0 = load
- `req_addr`, in, 32, byte address
- `req_wdata`, in, 32, store data, already lane-aligned
- `req_byteen`, in, 4, byte enables; 4'hF = word
- `req_ready`, out, 1, request accepted this cycle
- `exc_flush`, in, 1, pipeline flush; drops a pending response
- `rsp_valid`, out, 1, one-cycle completion pulse
- `rsp_rdata`, out, 32, raw read word; zero on store or error
- `rsp_err`, out, 1, access faulted; qualified by `rsp_valid`
- `stall`, out, 1, freeze F/D/E/M stages
- `s_valid`, out, 1, slave request
- `s_sel`, out, 3, one-hot slave select: [0] DM, [1] TC1, [2] TC2
- `s_we`, `s_addr`, `s_wdata`, `s_byteen`, out, 1/32/32/4, registered copy of the request
- `s_ready`, in, 3, per-slave completion
- `s_rdata_dm`, `s_rdata_tc1`, `s_rdata_tc2`, in, 32 each, slave read data, valid with the matching `s_ready` bit

## Operation
- FSM states are IDLE, BUSY and RESP. Reset enters IDLE.
- **IDLE:**
  - `req_ready` = 1.
  - When `req_valid` is high, latch we, addr, wdata and byteen, and decode the address. The decode is combinational on `req_addr`, inclusive at both window bounds.
  - Fault conditions: the address is in no window, or the address is in a TC window and `req_byteen` != 4'hF. On a fault, go to RESP with the error flag set and do not assert `s_valid`.
  - Otherwise, register `s_sel`, clear the timeout counter and go to BUSY.
- **BUSY:**
  - `s_valid` = 1, and `s_sel`, `s_we`, `s_addr`, `s_wdata`, `s_byteen` are held stable.
  - If `s_ready & s_sel` is nonzero, capture the selected rdata (zero for stores) and go to RESP with error = 0.
  - Otherwise, increment the counter. When the counter reaches TIMEOUT-1 with no ready, go to RESP with error = 1.
  - If ready and timeout occur in the same cycle, ready wins.
  - `s_ready` bits for unselected slaves are ignored.
- **RESP:**
  - `rsp_valid` = 1 for exactly one cycle, unless the response is flushed. Then return to IDLE.
  - `req_ready` = 0, so no back-to-back acceptance.
- **`exc_flush`:**
  - Sampled in BUSY or RESP, it sets a drop flag, so `rsp_valid` stays 0 in RESP.
  - An in-flight slave access is never aborted; a store still completes at the slave.
  - In IDLE, `exc_flush` blocks acceptance that cycle.
- **Output when idle:** `stall` = (IDLE and `req_valid` and not `exc_flush`) or BUSY.
- **Reset values:** all outputs 0 except `req_ready` = 1. The counter, drop flag and latched fields are cleared. A reset mid-BUSY abandons the slave handshake immediately.

## Timing
- The request is sampled only at the acceptance edge. The M stage holds it (it is stalled) but changes are ignored.
- Fault path: accept in cycle 0, `rsp_valid`+`rsp_err` in cycle 1. Total latency is 1.
- Slave path: accept in cycle 0, `s_valid` from cycle 1. With `s_ready` in cycle k, `rsp_valid` is in cycle k+1. Minimum latency is 2.
- Timeout: the first BUSY cycle counts as 0, so the error response follows TIMEOUT BUSY cycles.
- `stall` is low in the RESP cycle, so the M stage advances exactly as the response is consumed.

## Structure
- The shared definitions header holds the window constants, the FSM state encoding (2 bits) and the slave index constants. These are the same address constants the load-extend/exception logic uses.
- One sub-module, `dm_addr_decode`: combinational, `req_addr`/`req_byteen` → one-hot `sel` plus `fault`. It is reused by the M-stage exception check.
- The FSM, counter and latches live in `dm_bus_ctrl`.

## Test plan
- **DM load:** load of 0x0000_0010, DM `s_ready` on the 1st BUSY cycle with rdata 0xDEADBEEF → `rsp_valid` at cycle 2, rdata 0xDEADBEEF, err 0, `stall` high in cycles 0–1.
- **TC1 store:** word store to 0x7F04, data 0x5 → `s_sel`=3'b010, `s_we`=1, fields stable until ready after 3 cycles, then `rsp_valid` with err 0.
- **Faults without slave access:**
  - byteen 4'b0011 to 0x7F14 → `rsp_err` at cycle 1, `s_valid` never asserted.
  - Address 0x0000_3000 → same response.
- **Timeout:** TIMEOUT=8, DM never ready → exactly 8 BUSY cycles, then `rsp_err`. A variant with ready on the 8th cycle → err 0.
- **Flush during BUSY:** `exc_flush` pulse while a store is BUSY → store completes at the slave, no `rsp_valid`, FSM returns to IDLE.
- **Reset mid-op:** `reset` asserted mid-BUSY → `s_valid` drops asynchronously, `req_ready`=1, next request accepted normally.
